mem_port_arbiter: RTL and testbench

Two-requester memory arbiter that merges the CPU's split instruction and data memory ports onto one physical memory port sharing a single `mem_resp`. Sits between `cpu` and physical memory (or a unified cache) inside the top level. Each request is latched into registered downstream outputs and held until `mem_resp`, then routed back to the winning requester. Data requests have priority, and a starvation counter bounds instruction-fetch delay.

---
 rtl/mem_port_arbiter.sv | 100 ++++++++++
 tb/tb_mem_port_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Merges split instruction/data memory ports onto one memory port.
// Data requests win. A starvation counter bounds how long an instruction fetch can wait.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        inst_mem_read,
    input  logic        inst_mem_write,
    input  logic [1:0]  inst_mem_byte_enable,
    input  logic [15:0] inst_mem_addr,
    input  logic [15:0] inst_mem_wdata,
    output logic        inst_mem_resp,
    output logic [15:0] inst_mem_rdata,
    input  logic        data_mem_read,
    input  logic        data_mem_write,
    input  logic [1:0]  data_mem_byte_enable,
    input  logic [15:0] data_mem_addr,
    input  logic [15:0] data_mem_wdata,
    output logic        data_mem_resp,
    output logic [15:0] data_mem_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_byte_enable,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_resp,
    input  logic [15:0] mem_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0] state;
    logic [3:0] starve_cnt;
    logic       i_req;
    logic       d_req;
    logic       win_d;
    logic       win_i;

    assign i_req = inst_mem_read | inst_mem_write;
    assign d_req = data_mem_read | data_mem_write;

    // Data wins unless an instruction fetch has already waited out its limit.
    assign win_d = d_req & (~i_req | (starve_cnt < LIMIT));
    assign win_i = i_req & ~win_d;

    assign inst_mem_resp  = mem_resp & (state == GNT_I);
    assign data_mem_resp  = mem_resp & (state == GNT_D);
    assign inst_mem_rdata = mem_rdata;
    assign data_mem_rdata = mem_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            starve_cnt      <= 4'd0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_byte_enable <= 2'b00;
            mem_addr        <= 16'h0000;
            mem_wdata       <= 16'h0000;
        end else begin
            unique case (state)
                IDLE: begin
                    if (win_d) begin
                        state           <= GNT_D;
                        mem_read        <= data_mem_read;
                        mem_write       <= data_mem_write & ~data_mem_read;
                        mem_byte_enable <= data_mem_byte_enable;
                        mem_addr        <= data_mem_addr;
                        mem_wdata       <= data_mem_wdata;
                        if (!i_req)
                            starve_cnt <= 4'd0;
                        else if (starve_cnt < LIMIT)
                            starve_cnt <= starve_cnt + 4'd1;
                    end else if (win_i) begin
                        state           <= GNT_I;
                        mem_read        <= inst_mem_read;
                        mem_write       <= inst_mem_write & ~inst_mem_read;
                        mem_byte_enable <= inst_mem_byte_enable;
                        mem_addr        <= inst_mem_addr;
                        mem_wdata       <= inst_mem_wdata;
                        starve_cnt      <= 4'd0;
                    end
                end
                GNT_I, GNT_D: begin
                    if (mem_resp) begin
                        state     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grant order, latency,
// starvation bound, async reset and protocol corner cases.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        inst_mem_read, inst_mem_write;
    logic [1:0]  inst_mem_byte_enable;
    logic [15:0] inst_mem_addr, inst_mem_wdata;
    logic        inst_mem_resp;
    logic [15:0] inst_mem_rdata;
    logic        data_mem_read, data_mem_write;
    logic [1:0]  data_mem_byte_enable;
    logic [15:0] data_mem_addr, data_mem_wdata;
    logic        data_mem_resp;
    logic [15:0] data_mem_rdata;
    logic        mem_read, mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_resp;
    logic [15:0] mem_rdata;

    int total = 0;
    int bad = 0;
    int nd = 0;
    bit got_i = 1'b0;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .inst_mem_read(inst_mem_read),
        .inst_mem_write(inst_mem_write),
        .inst_mem_byte_enable(inst_mem_byte_enable),
        .inst_mem_addr(inst_mem_addr),
        .inst_mem_wdata(inst_mem_wdata),
        .inst_mem_resp(inst_mem_resp),
        .inst_mem_rdata(inst_mem_rdata),
        .data_mem_read(data_mem_read),
        .data_mem_write(data_mem_write),
        .data_mem_byte_enable(data_mem_byte_enable),
        .data_mem_addr(data_mem_addr),
        .data_mem_wdata(data_mem_wdata),
        .data_mem_resp(data_mem_resp),
        .data_mem_rdata(data_mem_rdata),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_resp(mem_resp),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        inst_mem_read = 0; inst_mem_write = 0;
        inst_mem_byte_enable = 2'b00;
        inst_mem_addr = 16'h0; inst_mem_wdata = 16'h0;
        data_mem_read = 0; data_mem_write = 0;
        data_mem_byte_enable = 2'b00;
        data_mem_addr = 16'h0; data_mem_wdata = 16'h0;
        mem_resp = 0; mem_rdata = 16'h0;

        #1;
        chk("rst_mem_read", 32'(mem_read), 0);
        chk("rst_mem_write", 32'(mem_write), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_resps", 32'({inst_mem_resp, data_mem_resp}), 0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // single instruction read, response 3 cycles after strobe
        inst_mem_read = 1; inst_mem_addr = 16'h1000;
        tick();
        chk("t1_mem_read", 32'(mem_read), 1);
        chk("t1_mem_addr", 32'(mem_addr), 32'h1000);
        chk("t1_mem_write", 32'(mem_write), 0);
        tick();
        chk("t1_no_early_resp", 32'(inst_mem_resp), 0);
        tick();
        chk("t1_hold_addr", 32'(mem_addr), 32'h1000);
        tick();
        mem_resp = 1; mem_rdata = 16'hBEEF;
        #1;
        chk("t1_inst_resp", 32'(inst_mem_resp), 1);
        chk("t1_inst_rdata", 32'(inst_mem_rdata), 32'hBEEF);
        chk("t1_data_resp", 32'(data_mem_resp), 0);
        inst_mem_read = 0;
        tick();
        mem_resp = 0;
        #1;
        chk("t1_idle_read", 32'(mem_read), 0);
        chk("t1_resp_pulse", 32'(inst_mem_resp), 0);

        // simultaneous: data write first, then inst read
        inst_mem_read = 1; inst_mem_addr = 16'h2000;
        data_mem_write = 1; data_mem_addr = 16'h3000;
        data_mem_wdata = 16'h00FF; data_mem_byte_enable = 2'b01;
        tick();
        chk("t2_write", 32'(mem_write), 1);
        chk("t2_read", 32'(mem_read), 0);
        chk("t2_wdata", 32'(mem_wdata), 32'h00FF);
        chk("t2_addr", 32'(mem_addr), 32'h3000);
        chk("t2_be", 32'(mem_byte_enable), 32'h1);
        mem_resp = 1;
        #1;
        chk("t2_data_resp", 32'(data_mem_resp), 1);
        chk("t2_inst_quiet", 32'(inst_mem_resp), 0);
        data_mem_write = 0;
        tick();
        mem_resp = 0;
        chk("t2_idle_gap", 32'({mem_read, mem_write}), 0);
        tick();
        chk("t2_inst_read", 32'(mem_read), 1);
        chk("t2_inst_addr", 32'(mem_addr), 32'h2000);
        mem_resp = 1;
        #1;
        chk("t2_inst_resp", 32'(inst_mem_resp), 1);
        inst_mem_read = 0;
        tick();
        mem_resp = 0;

        // starvation: inst held, data re-requesting
        inst_mem_read = 1; inst_mem_addr = 16'h4000;
        data_mem_read = 1; data_mem_addr = 16'h5000;
        for (int k = 0; k < 10 && !got_i; k++) begin
            tick();
            if (mem_read && mem_addr == 16'h4000) begin
                got_i = 1'b1;
                chk("t3_starve_clr", 32'(dut.starve_cnt), 0);
            end else if (mem_read && mem_addr == 16'h5000) begin
                nd++;
            end
            mem_resp = 1;
            if (got_i) begin
                inst_mem_read = 0;
                data_mem_read = 0;
            end
            tick();
            mem_resp = 0;
        end
        chk("t3_inst_granted", 32'(got_i), 1);
        chk("t3_data_grants", 32'(nd), 4);

        // reset during GNT_D before the response
        data_mem_read = 1; data_mem_addr = 16'h6000;
        tick();
        chk("t4_granted", 32'(mem_read), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t4_async_read", 32'(mem_read), 0);
        chk("t4_async_addr", 32'(mem_addr), 0);
        chk("t4_async_resp", 32'({inst_mem_resp, data_mem_resp}), 0);
        data_mem_read = 0;
        tick();
        reset_n = 1'b1;
        mem_resp = 1;
        #1;
        chk("t4_late_resp", 32'({inst_mem_resp, data_mem_resp}), 0);
        tick();
        chk("t4_late_resp2", 32'({inst_mem_resp, data_mem_resp}), 0);
        chk("t4_no_strobe", 32'({mem_read, mem_write}), 0);
        mem_resp = 0;
        tick();

        // illegal read+write from data port
        data_mem_read = 1; data_mem_write = 1; data_mem_addr = 16'h7000;
        tick();
        chk("t5_read", 32'(mem_read), 1);
        chk("t5_write", 32'(mem_write), 0);
        mem_resp = 1;
        data_mem_read = 0; data_mem_write = 0;
        tick();
        mem_resp = 0;
        tick();

        // response while idle is ignored
        mem_resp = 1; mem_rdata = 16'h1234;
        #1;
        chk("t6_idle_resp", 32'({inst_mem_resp, data_mem_resp}), 0);
        chk("t6_rdata_pass", 32'(data_mem_rdata), 32'h1234);
        tick();
        chk("t6_still_idle", 32'({mem_read, mem_write}), 0);
        mem_resp = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
